// File: rtl/unaligned_mem_ctrl.sv
// Word-organised memory with byte-granular unaligned access.
// Reads of WORD_BYTES bytes may start at any byte offset and span two
// adjacent words; the result appears one cycle after the request.
// Aligned writes complete in one cycle. Unaligned writes are streamed as a
// burst of beats: each beat's head merges into the current word and its tail
// is carried into the next word. A final tail cycle merges the last carry
// with the old contents of the following word.
// Byte 0 of a word occupies the MSBs (big-endian).
module unaligned_mem_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_BYTES = 8,   // 2, 4, 8 or 16
  localparam int LO_WIDTH = $clog2(WORD_BYTES)
) (
  input  logic                    i_clk,
  input  logic                    i_areset_n,
  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [WORD_BYTES*8-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0]   i_addr_hi,
  input  logic [LO_WIDTH-1:0]     i_addr_lo,
  input  logic                    i_error_clear,
  output logic                    o_busy,
  output logic                    o_error,
  output logic [WORD_BYTES*8-1:0] o_rdata,
  output logic                    o_rvalid
);

  localparam int W     = WORD_BYTES * 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Shift amounts range over 0..W bits, so one extra bit beyond the byte offset.
  localparam int SHW   = LO_WIDTH + 4;
  localparam logic [SHW-1:0] W_BITS = SHW'(W);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_FIRST  = 3'd1;
  localparam logic [2:0] ST_WR_STREAM = 3'd2;
  localparam logic [2:0] ST_WR_TAIL   = 3'd3;
  localparam logic [2:0] ST_ERROR     = 3'd4;

  // Storage
  logic [W-1:0] mem [DEPTH];

  // Control state and burst context
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;   // word address of the latest beat
  logic [LO_WIDTH-1:0]   lo_q, lo_d;       // byte offset shared by the burst
  logic [W-1:0]          data_q, data_d;   // latest beat
  logic [W-1:0]          prev_q, prev_d;   // beat before the latest one
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Read ports and write port
  logic [ADDR_WIDTH-1:0] rd_addr0, rd_addr1;
  logic [W-1:0]          rd_word0, rd_word1;
  logic [W-1:0]          rd_window;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [W-1:0]          mem_wdata;

  // Byte-merge helpers for the latched offset and the requested offset
  logic [SHW-1:0] lo_shift, tail_shift;
  logic [SHW-1:0] rd_lo_shift, rd_tail_shift;
  logic [W-1:0]   head_mask;   // ones over bytes 0..L-1
  logic           beat_ok;

  assign addr_inc      = addr_q + ADDR_WIDTH'(1);
  assign lo_shift      = {1'b0, lo_q, 3'b000};
  assign tail_shift    = W_BITS - lo_shift;
  assign rd_lo_shift   = {1'b0, i_addr_lo, 3'b000};
  assign rd_tail_shift = W_BITS - rd_lo_shift;
  assign head_mask     = ~({W{1'b1}} >> lo_shift);
  assign beat_ok       = (i_addr_hi == addr_inc) && (i_addr_lo == lo_q);

  assign o_busy  = (state_q != ST_IDLE);
  assign o_error = (state_q == ST_ERROR);

  // Select which word the first read port fetches: the requested word in
  // IDLE, otherwise the word whose old bytes get merged this cycle.
  always_comb begin
    case (state_q)
      ST_WR_FIRST: rd_addr0 = addr_q;
      ST_WR_TAIL:  rd_addr0 = addr_inc;
      default:     rd_addr0 = i_addr_hi;
    endcase
  end

  assign rd_addr1 = rd_addr0 + ADDR_WIDTH'(1);
  assign rd_word0 = mem[rd_addr0];
  assign rd_word1 = mem[rd_addr1];

  // WORD_BYTES bytes starting at byte i_addr_lo of the word pair; a shift by
  // the full word width yields zero, which covers the aligned case.
  assign rd_window = (rd_word0 << rd_lo_shift) | (rd_word1 >> rd_tail_shift);

  // Next-state, burst bookkeeping and memory write-port decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    data_d    = data_q;
    prev_d    = prev_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write is served as a read only.
        if (!i_read && i_write) begin
          if (i_addr_lo == '0) begin
            mem_we    = 1'b1;
            mem_waddr = i_addr_hi;
            mem_wdata = i_wdata;
          end else begin
            state_d = ST_WR_FIRST;
            addr_d  = i_addr_hi;
            lo_d    = i_addr_lo;
            data_d  = i_wdata;
          end
        end
      end

      ST_WR_FIRST, ST_WR_STREAM: begin
        // The word for the current beat is always committed, even if the
        // incoming request turns out to be a protocol error.
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        if (state_q == ST_WR_FIRST) begin
          mem_wdata = (rd_word0 & head_mask) | (data_q >> lo_shift);
        end else begin
          mem_wdata = (prev_q << tail_shift) | (data_q >> lo_shift);
        end

        if (i_read) begin
          state_d = ST_ERROR;
        end else if (i_write) begin
          if (beat_ok) begin
            state_d = ST_WR_STREAM;
            addr_d  = addr_inc;
            prev_d  = data_q;
            data_d  = i_wdata;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_WR_TAIL;
        end
      end

      ST_WR_TAIL: begin
        // Carried bytes of the last beat, then the old bytes L..end.
        mem_we    = 1'b1;
        mem_waddr = addr_inc;
        mem_wdata = (data_q << tail_shift) | (rd_word0 & ~head_mask);
        state_d   = (i_read || i_write) ? ST_ERROR : ST_IDLE;
      end

      ST_ERROR: begin
        if (i_error_clear) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and burst context registers.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_areset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      prev_q  <= prev_d;
    end
  end

  // Storage write port; writes are suppressed while reset is held.
  always_ff @(posedge i_clk) begin
    // NOTE: the array is deliberately not reset so it can map onto RAM.
    if (mem_we && i_areset_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read response; data is forced to zero when not valid.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else if ((state_q == ST_IDLE) && i_read) begin
      o_rvalid <= 1'b1;
      o_rdata  <= rd_window;
    end else begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end
  end

endmodule
